// File: rtl/param_alu_unit.sv
// Registered, parametrised ALU: single-cycle ops pass through EXEC, and MUL is a WIDTH-step shift-add.
// Define PALU_MUL_EN to build the multiplier; without it opcode 8 reports error and result_hi stays 0.
module param_alu_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             error,
  output logic             busy,
  output logic             valid
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_PASS = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef PALU_MUL_EN
    MULT = 2'd2,
`endif
    EXEC = 2'd1
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_r, zero_r, error_r, busy_r, valid_r;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_carry_s, alu_err_s;

`ifdef PALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam int         CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  // prod_r holds {partial high half, remaining multiplier bits}; it shifts right once per step.
  logic [2*WIDTH-1:0] prod_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   result_hi_r;
  logic [WIDTH:0]     mul_sum_s;
  logic               start_mul_s;

  assign start_mul_s = (operation == OP_MUL);
  assign mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
                     + (prod_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
  assign result_hi   = result_hi_r;
`else
  assign result_hi   = {WIDTH{1'b0}};
`endif

  // Single-cycle operation result from the latched operands.
  always_comb begin
    alu_res_s   = {WIDTH{1'b0}};
    alu_carry_s = 1'b0;
    alu_err_s   = 1'b0;
    case (op_r)
      OP_ADD:  {alu_carry_s, alu_res_s} = {1'b0, a_r} + {1'b0, b_r};
      OP_SUB:  begin alu_res_s = a_r - b_r; alu_carry_s = (a_r < b_r); end
      OP_AND:  alu_res_s = a_r & b_r;
      OP_OR:   alu_res_s = a_r | b_r;
      OP_XOR:  alu_res_s = a_r ^ b_r;
      OP_NOT:  alu_res_s = ~a_r;
      OP_SHL:  begin alu_res_s = {a_r[WIDTH-2:0], 1'b0}; alu_carry_s = a_r[WIDTH-1]; end
      OP_SHR:  begin alu_res_s = {1'b0, a_r[WIDTH-1:1]}; alu_carry_s = a_r[0]; end
      OP_PASS: alu_res_s = b_r;
      default: alu_err_s = 1'b1;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!enable) state_nxt_s = IDLE;
`ifdef PALU_MUL_EN
        else if (start_mul_s) state_nxt_s = MULT;
`endif
        else state_nxt_s = EXEC;
      end
      EXEC: state_nxt_s = IDLE;
`ifdef PALU_MUL_EN
      MULT: begin
        if (cnt_r == CNT_LAST) state_nxt_s = IDLE;
        else state_nxt_s = MULT;
      end
`endif
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Operand latch, multiplier steps and registered outputs; valid_r defaults low so it pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_r     <= 4'd0;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      zero_r   <= 1'b0;
      error_r  <= 1'b0;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
`ifdef PALU_MUL_EN
      prod_r      <= {(2*WIDTH){1'b0}};
      cnt_r       <= {CW{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
`endif
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (enable) begin
            op_r   <= operation;
            a_r    <= operand_a;
            b_r    <= operand_b;
            busy_r <= 1'b1;
`ifdef PALU_MUL_EN
            cnt_r  <= {CW{1'b0}};
            prod_r <= {{WIDTH{1'b0}}, operand_b};
`endif
          end
        end
        EXEC: begin
          result_r <= alu_res_s;
          carry_r  <= alu_carry_s;
          zero_r   <= (alu_res_s == {WIDTH{1'b0}});
          error_r  <= alu_err_s;
          valid_r  <= 1'b1;
          busy_r   <= 1'b0;
`ifdef PALU_MUL_EN
          result_hi_r <= {WIDTH{1'b0}};
`endif
        end
`ifdef PALU_MUL_EN
        MULT: begin
          if (cnt_r == CNT_LAST) begin
            result_r    <= prod_r[WIDTH-1:0];
            result_hi_r <= prod_r[2*WIDTH-1:WIDTH];
            carry_r     <= 1'b0;
            zero_r      <= (prod_r == {(2*WIDTH){1'b0}});
            error_r     <= 1'b0;
            valid_r     <= 1'b1;
            busy_r      <= 1'b0;
          end else begin
            prod_r <= {mul_sum_s, prod_r[WIDTH-1:1]};
            cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
`endif
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign result = result_r;
  assign carry  = carry_r;
  assign zero   = zero_r;
  assign error  = error_r;
  assign busy   = busy_r;
  assign valid  = valid_r;

endmodule
